instr_packer: RTL
=================

INSTR_PACKER -- requirements
Module: instr_packer

Interface
REQ-001 The block SHALL have parameter PAD_HALF, default 16'h0001 (C.NOP), the halfword used to pad a flushed partial word.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  in_instr holds a valid uncompressed RV32I instruction.
REQ-005 in_ready  output  1  block accepts in_instr this cycle; transfer occurs when in_valid=1 and in_ready=1.
REQ-006 in_instr  input  32  instruction, ISA bit order (bits [1:0]=2'b11).
REQ-007 flush  input  1  request to pad and emit any pending halfword.
REQ-008 out_valid  output  1  out_word holds a completed memory word.
REQ-009 out_ready  input  1  downstream accepts out_word; transfer occurs when out_valid=1 and out_ready=1.
REQ-010 out_word  output  32  packed word in cache byte-lane order: byte-reverse of the little-endian packed word P, i.e. {P[7:0],P[15:8],P[23:16],P[31:24]}.

Function
REQ-011 Each accepted instruction SHALL be compressed when compressible (REQ-012), else kept as 32 bits.
REQ-012 Compressible forms: C.LI (addi rd!=0, rs1=x0, imm in [-32,31]); C.ADDI (addi rd=rs1!=0, imm!=0, imm in [-32,31]); C.MV (add rd!=0, rs1=x0, rs2!=0); C.ADD (add rd=rs1!=0, rs2!=0); C.LW/C.SW (regs in x8-x15, offset multiple of 4 in [0,124]); all other instructions SHALL stay 32 bits.
REQ-013 State machine: EMPTY (no pending halfword) and HALF (16-bit hold register valid).
REQ-014 EMPTY + compressed c: hold<=c, go HALF, no output word.
REQ-015 EMPTY + 32-bit i: emit P=i, stay EMPTY.
REQ-016 HALF + compressed c: emit P={c,hold}, go EMPTY.
REQ-017 HALF + 32-bit i: emit P={i[15:0],hold}, hold<=i[31:16], stay HALF (straddling instruction).
REQ-018 flush in HALF with in_valid=0 and in_ready=1: emit P={PAD_HALF,hold}, go EMPTY; flush in EMPTY SHALL be a no-op.
REQ-019 flush SHALL be ignored while in_valid=1; the source holds flush until the cycle after its last instruction is accepted.
REQ-020 Output SHALL be a single registered slot; an emitted word appears on out_valid/out_word the cycle after the accepting edge (latency 1).
REQ-021 in_ready SHALL equal (!out_valid || out_ready); a word is never dropped or overwritten.
REQ-022 While out_valid=1 and out_ready=0, out_word SHALL remain stable.
REQ-023 Output transfer and new emission in the same cycle SHALL load the new word with out_valid staying 1 (full throughput, one word per cycle).

Reset
REQ-024 On rst_n=0 at a clock edge: state<=EMPTY, hold<=0, out_valid<=0, out_word<=0; any pending halfword SHALL be discarded, including mid-operation.
REQ-025 in_ready SHALL be 1 in the cycle following reset.

Configuration
REQ-026 Macro RVC_COMPRESS_EN: defined, REQ-011/012 compression SHALL be active; undefined, no instruction is compressed, state SHALL remain EMPTY, flush is a no-op, and every accepted instruction is emitted as P=in_instr with identical handshake and latency.

Structure
REQ-027 Shared package rvc_pkg SHALL hold opcode/funct3 constants, the C.NOP constant 16'h0001, and the EMPTY/HALF state enum.
REQ-028 Compression SHALL be a combinational sub-module rvc_compressor (in: instr[31:0]; out: is_c, c_instr[15:0]); instr_packer holds all sequential logic.

Verification
REQ-029 EMPTY, accept 0x00500513 (addi x10,x0,5) -> no output, state HALF, hold=0x4515.
REQ-030 Then accept 0x123452B7 (lui x5,0x12345) -> next cycle out_word=0x1545B752, hold=0x1234, state HALF.
REQ-031 Then flush with in_valid=0 -> out_word=0x34120100, state EMPTY.
REQ-032 out_valid=1, out_ready=0 for 5 cycles -> in_ready=0, out_word unchanged; raise out_ready -> transfer, in_ready=1 same cycle.
REQ-033 State HALF, assert rst_n=0 one cycle -> out_valid=0, state EMPTY; following flush emits nothing.
REQ-034 RVC_COMPRESS_EN undefined, accept 0x00500513 -> next cycle out_word=0x13055000.

Source files
------------

// File: rtl/rvc_pkg.sv
// rtl/rvc_pkg.sv - shared RV32I/RVC constants, packer state type and byte-lane helper
package rvc_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [2:0] F3_WORD    = 3'b010;

    localparam logic [6:0] F7_ADD     = 7'b0000000;

    localparam logic [15:0] C_NOP     = 16'h0001;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } pack_state_t;

    // Little-endian packed word to cache byte-lane order.
    function automatic logic [31:0] byte_rev(input logic [31:0] p);
        return {p[7:0], p[15:8], p[23:16], p[31:24]};
    endfunction

endpackage

// File: rtl/rvc_compressor.sv
// rtl/rvc_compressor.sv - combinational RV32I to RVC encoder for LI/ADDI/MV/ADD/LW/SW
module rvc_compressor
    import rvc_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_c,
    output logic [15:0] c_instr
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       imm6_ok;

    assign opc     = instr[6:0];
    assign rd      = instr[11:7];
    assign f3      = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign f7      = instr[31:25];
    // I-immediate fits a signed 6-bit field when bits [11:5] are all sign copies
    assign imm6_ok = (instr[31:25] == {7{instr[25]}});

    // Recognise each compressible form and build its 16-bit encoding
    always_comb begin
        is_c    = 1'b0;
        c_instr = 16'h0000;
        case (opc)
            OPC_OP_IMM: begin
                if (f3 == F3_ADD && rd != 5'd0 && imm6_ok) begin
                    if (rs1 == 5'd0) begin
                        is_c    = 1'b1;
                        c_instr = {3'b010, instr[25], rd, instr[24:20], 2'b01};
                    end else if (rs1 == rd && instr[31:20] != 12'd0) begin
                        is_c    = 1'b1;
                        c_instr = {3'b000, instr[25], rd, instr[24:20], 2'b01};
                    end
                end
            end
            OPC_OP: begin
                if (f3 == F3_ADD && f7 == F7_ADD && rd != 5'd0 && rs2 != 5'd0) begin
                    if (rs1 == 5'd0) begin
                        is_c    = 1'b1;
                        c_instr = {4'b1000, rd, rs2, 2'b10};
                    end else if (rs1 == rd) begin
                        is_c    = 1'b1;
                        c_instr = {4'b1001, rd, rs2, 2'b10};
                    end
                end
            end
            OPC_LOAD: begin
                // offset = instr[31:20]; must be 0..124 and word aligned
                if (f3 == F3_WORD && rd[4:3] == 2'b01 && rs1[4:3] == 2'b01
                    && instr[31:27] == 5'd0 && instr[21:20] == 2'd0) begin
                    is_c    = 1'b1;
                    c_instr = {3'b010, instr[25:23], rs1[2:0], instr[22], instr[26],
                               rd[2:0], 2'b00};
                end
            end
            OPC_STORE: begin
                // offset = {instr[31:25], instr[11:7]}
                if (f3 == F3_WORD && rs2[4:3] == 2'b01 && rs1[4:3] == 2'b01
                    && instr[31:27] == 5'd0 && instr[8:7] == 2'd0) begin
                    is_c    = 1'b1;
                    c_instr = {3'b110, instr[25], instr[11:10], rs1[2:0], instr[9], instr[26],
                               rs2[2:0], 2'b00};
                end
            end
            default: begin
                is_c    = 1'b0;
                c_instr = 16'h0000;
            end
        endcase
    end

endmodule

// File: rtl/instr_packer.sv
// rtl/instr_packer.sv - packs instructions (RVC-compressed when RVC_COMPRESS_EN is defined) into 32-bit words
module instr_packer
    import rvc_pkg::*;
#(
    parameter logic [15:0] PAD_HALF = C_NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word
);

    pack_state_t state;
    pack_state_t state_n;
    logic [15:0] hold;
    logic [15:0] hold_n;
    logic        is_c;
    logic [15:0] c_instr;
    logic        accept;
    logic        do_flush;
    logic        emit;
    logic [31:0] emit_word;

`ifdef RVC_COMPRESS_EN
    rvc_compressor u_rvc_compressor (
        .instr   (in_instr),
        .is_c    (is_c),
        .c_instr (c_instr)
    );
`else
    // Without compression every instruction is emitted whole, so HALF is never entered
    assign is_c    = 1'b0;
    assign c_instr = 16'h0000;
`endif

    // The single output slot can take a new word when empty or draining this cycle
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign do_flush = flush && !in_valid && in_ready && (state == ST_HALF);

    // Next-state, hold update and word to emit for the accepted instruction or flush
    always_comb begin
        state_n   = state;
        hold_n    = hold;
        emit      = 1'b0;
        emit_word = 32'h0000_0000;
        if (accept) begin
            if (state == ST_EMPTY) begin
                if (is_c) begin
                    hold_n  = c_instr;
                    state_n = ST_HALF;
                end else begin
                    emit      = 1'b1;
                    emit_word = in_instr;
                end
            end else begin
                emit = 1'b1;
                if (is_c) begin
                    emit_word = {c_instr, hold};
                    state_n   = ST_EMPTY;
                end else begin
                    // upper half of a straddling instruction waits for the next word
                    emit_word = {in_instr[15:0], hold};
                    hold_n    = in_instr[31:16];
                end
            end
        end else if (do_flush) begin
            emit      = 1'b1;
            emit_word = {PAD_HALF, hold};
            state_n   = ST_EMPTY;
        end
    end

    // Packing state and hold register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            hold  <= 16'h0000;
        end else begin
            state <= state_n;
            hold  <= hold_n;
        end
    end

    // Registered output slot; loads on emit, clears once the word is taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_word  <= 32'h0000_0000;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_word  <= byte_rev(emit_word);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
